core_sequencer: RTL
===================

Name: core_sequencer

Overview:
Top-level sequencer for the Cortex-M0 datapath.
- Out of reset it performs the vector-table boot: it loads SP from VTOR+0 and PC from VTOR+4, then initialises LR, IPSR and PRIMASK.
- It then runs the fetch/execute loop. Each loop it fetches a 16-bit Thumb instruction from memory, hands it to the execute stage, and updates PC on completion.
- It drives the memory request port and the ld_* strobes of the core register file.

Parameters:
- VTOR, 32'h00000000, vector table base; must be word aligned.
- MEM_TIMEOUT, 16, number of cycles mem_req may stay high without mem_ready before entering FAULT (range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory read request.
- mem_addr  out  32  word address of the request; bits [1:0] always 0.
- mem_ready  in  1  read data valid this cycle.
- mem_rdata  in  32  read data.
- wr_en  out  1  memory write enable; held 0 by this block.
- ld_sp, ld_lr, ld_pc, ld_ipsr, ld_primask  out  1 each  one-cycle core-register load strobes.
- w_sp  out  32  SP write value.
- w_lr  out  32  LR write value.
- w_pc  out  32  PC write value; always equals the internal pc_q.
- w_ipsr  out  6  IPSR write value.
- w_pmask  out  1  PRIMASK write value.
- instr  out  16  fetched instruction; holds its value until the next fetch.
- instr_valid  out  1  one-cycle pulse when instr is new.
- exec_done  in  1  execute stage finished the current instruction.
- branch  in  1  qualifies exec_done: PC takes branch_target.
- branch_target  in  32  next PC when branch=1.
- fault  out  1  sticky fault flag.
- state  out  3  current state, for debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RST_SP(0), pc_q=0, instr=0, timeout counter=0.
  - All outputs are 0: mem_req, mem_addr, wr_en, every ld_*, every w_*, instr_valid, fault.
  - mem_req drops immediately even in the middle of a transaction.
  - The first request is issued in the first cycle after rst rises.
- Memory handshake:
  - mem_req is held high with a stable mem_addr until mem_ready is sampled high on a rising edge.
  - mem_rdata is captured on that same edge.
  - mem_req is low for at least the following cycle.
  - mem_ready while mem_req=0 is ignored.
- Timeout:
  - The counter increments every cycle that mem_req=1 and mem_ready=0, and clears on each accepted transfer.
  - When it reaches MEM_TIMEOUT the block goes to FAULT.
- All ld_* and instr_valid are registered pulses, exactly one cycle wide.
- States and transitions:
  - RST_SP(0): mem_addr=VTOR. On ready: w_sp=rdata&~3 and ld_sp pulses next cycle; go to RST_PC.
  - RST_PC(1): mem_addr=VTOR+4. On ready:
    - If rdata[0]=0 (non-Thumb): go to FAULT.
    - Otherwise: pc_q=rdata&~1, ld_pc pulses; go to INIT.
  - INIT(2): single cycle. Pulses ld_lr (w_lr=32'hFFFFFFFF), ld_ipsr (w_ipsr=0) and ld_primask (w_pmask=0) together; go to FETCH.
  - FETCH(3): mem_addr={pc_q[31:2],2'b00}. On ready:
    - instr = pc_q[1] ? rdata[31:16] : rdata[15:0].
    - instr_valid pulses next cycle; go to EXEC.
  - EXEC(4): waits for exec_done (no timeout). On exec_done:
    - pc_q = branch ? (branch_target&~1) : pc_q+2, with 32-bit wrap-around (0xFFFFFFFE+2 -> 0).
    - ld_pc pulses; go to FETCH.
    - exec_done in the same cycle as the instr_valid pulse is accepted.
  - FAULT(5): fault=1, mem_req=0, no strobes. Exits only through reset.
- exec_done, branch and branch_target are ignored outside EXEC.
- Latency: fetch-to-instr_valid is mem latency + 1 cycle. With zero-wait memory (mem_ready in the cycle after mem_req rises), the minimum loop is 4 cycles per instruction.

Test Plan:
- Boot: mem[0]=32'h20001003, mem[4]=32'h00000101, zero-wait memory. Required: ld_sp with w_sp=32'h20001000; ld_pc with w_pc=32'h00000100; then an INIT cycle with ld_lr (w_lr=FFFFFFFF), ld_ipsr (0) and ld_primask (0); then a fetch at 32'h00000100.
- Sequential halfwords: mem[0x100]=32'hBBBBAAAA, exec_done held high. Required: instr=AAAA, then BBBB, with the second fetch also at 0x100; the third fetch is at 0x104; w_pc steps 0x102, 0x104.
- Branch: in EXEC, exec_done=1, branch=1, branch_target=32'h00000203. Required: ld_pc with w_pc=32'h00000202; next fetch at 0x200; instr = upper halfword.
- Non-Thumb vector: mem[4]=32'h00000100. Required: no ld_pc pulse; state=5; fault=1 and mem_req=0 held indefinitely.
- Timeout and wait states: mem_ready delayed 3 cycles gives normal completion. mem_ready never asserted in FETCH gives fault=1 exactly MEM_TIMEOUT=16 cycles after mem_req rises.
- Reset mid-fetch: rst low while mem_req=1. Required: mem_req=0 asynchronously, all outputs 0, state=0; after release the boot sequence restarts at VTOR.

Source files
------------

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//
// Top-level sequencer for the Cortex-M0 datapath.
//   * Out of reset: vector-table boot. SP is loaded from VTOR+0, PC from
//     VTOR+4, then LR, IPSR and PRIMASK are initialised in one cycle.
//   * Then the fetch/execute loop: fetch a 16-bit Thumb halfword, hand it to
//     the execute stage, update PC when the execute stage reports completion.
//
// Ports
//   clk, rst              system clock (rising edge), async active-low reset
//   mem_req/mem_addr      word-aligned read request, held until mem_ready
//   mem_ready/mem_rdata   read data valid / read data (captured on that edge)
//   wr_en                 memory write enable, always 0
//   ld_sp..ld_primask     one-cycle core register load strobes
//   w_sp..w_pmask         register write values (w_pc mirrors the PC)
//   instr/instr_valid     fetched halfword and its one-cycle "new" pulse
//   exec_done/branch/     execute-stage completion, branch qualifier and
//   branch_target         branch destination (sampled in EXEC only)
//   fault                 sticky fault flag (left only through reset)
//   state                 current FSM state, for debug
// -----------------------------------------------------------------------------
module core_sequencer #(
    parameter logic [31:0] VTOR        = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wr_en,
    output logic        ld_sp,
    output logic        ld_lr,
    output logic        ld_pc,
    output logic        ld_ipsr,
    output logic        ld_primask,
    output logic [31:0] w_sp,
    output logic [31:0] w_lr,
    output logic [31:0] w_pc,
    output logic [5:0]  w_ipsr,
    output logic        w_pmask,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        RST_SP = 3'd0,
        RST_PC = 3'd1,
        INIT   = 3'd2,
        FETCH  = 3'd3,
        EXEC   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    // Outstanding memory request: valid flag plus its (stable) address.
    typedef struct packed {
        logic        vld;
        logic [31:0] addr;
    } mreq_t;

    // Core register load strobes, registered so each is exactly one cycle.
    typedef struct packed {
        logic sp;
        logic pc;
        logic lr;
        logic ipsr;
        logic pmask;
    } ld_t;

    // The timeout fires on the stall cycle that would bring the count to
    // MEM_TIMEOUT, so fault rises exactly MEM_TIMEOUT cycles after mem_req.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    mreq_t       mreq_q, mreq_d;
    ld_t         ld_q, ld_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        ivld_q, ivld_d;
    logic [31:0] w_sp_q, w_sp_d;
    logic [31:0] w_lr_q, w_lr_d;
    logic [5:0]  w_ipsr_q, w_ipsr_d;
    logic        w_pmask_q, w_pmask_d;
    logic [7:0]  tmo_q, tmo_d;

    logic accept;
    logic stall;

    // mem_ready is only meaningful while a request is outstanding.
    assign accept = mreq_q.vld & mem_ready;
    assign stall  = mreq_q.vld & ~mem_ready;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RST_SP;
            mreq_q    <= '0;
            ld_q      <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            ivld_q    <= 1'b0;
            w_sp_q    <= '0;
            w_lr_q    <= '0;
            w_ipsr_q  <= '0;
            w_pmask_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            mreq_q    <= mreq_d;
            ld_q      <= ld_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ivld_q    <= ivld_d;
            w_sp_q    <= w_sp_d;
            w_lr_q    <= w_lr_d;
            w_ipsr_q  <= w_ipsr_d;
            w_pmask_q <= w_pmask_d;
            tmo_q     <= tmo_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    //
    // Memory-using states share one pattern: with no request outstanding,
    // raise mem_req for this state's address; once accepted, drop mem_req
    // (so it is low for at least one cycle) and move on. The request is
    // therefore issued one cycle after entering the state, which is what
    // makes the zero-wait loop FETCH(idle), FETCH(req), FETCH(ready), EXEC.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        mreq_d    = mreq_q;
        ld_d      = '0;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ivld_d    = 1'b0;
        w_sp_d    = w_sp_q;
        w_lr_d    = w_lr_q;
        w_ipsr_d  = w_ipsr_q;
        w_pmask_d = w_pmask_q;
        tmo_d     = tmo_q;

        if (stall) begin
            tmo_d = tmo_q + 8'd1;
        end else if (accept) begin
            tmo_d = '0;
        end

        case (state_q)
            RST_SP: begin
                if (!mreq_q.vld) begin
                    mreq_d.vld  = 1'b1;
                    mreq_d.addr = VTOR;
                end else if (mem_ready) begin
                    mreq_d.vld = 1'b0;
                    w_sp_d     = {mem_rdata[31:2], 2'b00};
                    ld_d.sp    = 1'b1;
                    state_d    = RST_PC;
                end
            end

            RST_PC: begin
                if (!mreq_q.vld) begin
                    mreq_d.vld  = 1'b1;
                    mreq_d.addr = VTOR + 32'd4;
                end else if (mem_ready) begin
                    mreq_d.vld = 1'b0;
                    // A reset vector without the Thumb bit cannot execute.
                    if (!mem_rdata[0]) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = {mem_rdata[31:1], 1'b0};
                        ld_d.pc = 1'b1;
                        state_d = INIT;
                    end
                end
            end

            INIT: begin
                ld_d.lr    = 1'b1;
                ld_d.ipsr  = 1'b1;
                ld_d.pmask = 1'b1;
                w_lr_d     = 32'hFFFF_FFFF;
                w_ipsr_d   = '0;
                w_pmask_d  = 1'b0;
                state_d    = FETCH;
            end

            FETCH: begin
                if (!mreq_q.vld) begin
                    mreq_d.vld  = 1'b1;
                    mreq_d.addr = {pc_q[31:2], 2'b00};
                end else if (mem_ready) begin
                    mreq_d.vld = 1'b0;
                    // pc_q[1] picks the halfword within the fetched word.
                    instr_d    = pc_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
                    ivld_d     = 1'b1;
                    state_d    = EXEC;
                end
            end

            EXEC: begin
                // No memory traffic here, so no timeout; exec_done may
                // arrive in the very cycle instr_valid is high.
                if (exec_done) begin
                    pc_d    = branch ? {branch_target[31:1], 1'b0}
                                     : pc_q + 32'd2;
                    ld_d.pc = 1'b1;
                    state_d = FETCH;
                end
            end

            FAULT: begin
                mreq_d.vld = 1'b0;
            end

            default: begin
                mreq_d.vld = 1'b0;
                state_d    = FAULT;
            end
        endcase

        // A request that has waited too long overrides whatever the state
        // above decided; a ready in the same cycle still wins.
        if (stall && (tmo_q == TMO_LAST)) begin
            mreq_d.vld = 1'b0;
            state_d    = FAULT;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_req     = mreq_q.vld;
    assign mem_addr    = mreq_q.addr;
    assign wr_en       = 1'b0;
    assign ld_sp       = ld_q.sp;
    assign ld_pc       = ld_q.pc;
    assign ld_lr       = ld_q.lr;
    assign ld_ipsr     = ld_q.ipsr;
    assign ld_primask  = ld_q.pmask;
    assign w_sp        = w_sp_q;
    assign w_lr        = w_lr_q;
    assign w_pc        = pc_q;
    assign w_ipsr      = w_ipsr_q;
    assign w_pmask     = w_pmask_q;
    assign instr       = instr_q;
    assign instr_valid = ivld_q;
    assign fault       = (state_q == FAULT);
    assign state       = state_q;

endmodule
